// File: rtl/usb_serial_pump.sv
// usb_serial_pump: byte TX FIFO feeding a Wishbone master that polls a USB serial
// core's status register and moves data. The RX path is built only when USB_SERIAL_PUMP_RX_EN is defined.
module usb_serial_pump #(
  parameter int unsigned TX_DEPTH    = 8,
  parameter logic [7:0]  BASE_ADR    = 8'h20,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [7:0]                 rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [$clog2(TX_DEPTH):0]  tx_level,
  output logic                       usb_configured,
  output logic                       bus_error,
  output logic [7:0]                 wb_adr_o,
  output logic [7:0]                 wb_dat_o,
  input  logic [7:0]                 wb_dat_i,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic                       wb_we_o,
  input  logic                       wb_ack_i
);

  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = 8;
  localparam logic [7:0]  STATUS_ADR = 8'(BASE_ADR + 8'd1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POLL   = 3'd1,
    DECIDE = 3'd2,
    TX_WR  = 3'd3,
    RX_RD  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [7:0]    adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          bus_error_q, bus_error_d;

  logic          rx_avail_q, rx_avail_d;
  logic          tx_space_q, tx_space_d;
  logic          cfg_q, cfg_d;
  logic          prefer_rx_q, prefer_rx_d;

  logic          ack_c, timeout_c, bus_done_c;
  logic          push_c, pop_c, tx_ok_c, rx_ok_c;

  // Acks only count while our strobe is up; timeout fires on the last allowed cycle.
  assign ack_c      = wb_ack_i && stb_q;
  assign timeout_c  = stb_q && !wb_ack_i &&
                      ((9'(to_cnt_q) + 9'd1) == 9'(ACK_TIMEOUT));
  assign bus_done_c = ack_c || timeout_c;

  assign tx_ready = (count_q != CW'(TX_DEPTH)) && !rst;
  assign push_c   = tx_valid && tx_ready;
  assign pop_c    = (state_q == TX_WR) && ack_c;
  assign tx_ok_c  = tx_space_q && cfg_q && (count_q != '0);

`ifdef USB_SERIAL_PUMP_RX_EN
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_data_q, rx_data_d;

  assign rx_ok_c  = rx_avail_q && !rx_valid_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
`else
  logic          unused_rx;

  assign rx_ok_c   = 1'b0;
  assign rx_valid  = 1'b0;
  assign rx_data   = 8'h00;
  assign unused_rx = ^{rx_ready, rx_avail_q, wb_dat_i[6:2]};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = POLL;
      POLL: begin
        if (ack_c)          state_d = DECIDE;
        else if (timeout_c) state_d = IDLE;
      end
      DECIDE: begin
        if (tx_ok_c && rx_ok_c) state_d = prefer_rx_q ? RX_RD : TX_WR;
        else if (tx_ok_c)       state_d = TX_WR;
        else if (rx_ok_c)       state_d = RX_RD;
        else                    state_d = IDLE;
      end
      TX_WR, RX_RD: begin
        if (bus_done_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus launch/teardown, FIFO pointers, status latch and RX holding register
  always_comb begin
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    to_cnt_d    = '0;
    bus_error_d = 1'b0;
    rx_avail_d  = rx_avail_q;
    tx_space_d  = tx_space_q;
    cfg_d       = cfg_q;
    prefer_rx_d = prefer_rx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
`ifdef USB_SERIAL_PUMP_RX_EN
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
`endif

    if (stb_q && !bus_done_c) to_cnt_d = to_cnt_q + TW'(1);

    if (bus_done_c) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
      we_d  = 1'b0;
      adr_d = 8'h00;
      dat_d = 8'h00;
    end
    if (timeout_c) bus_error_d = 1'b1;

    if ((state_q == POLL) && ack_c) begin
      rx_avail_d = wb_dat_i[0];
      tx_space_d = wb_dat_i[1];
      cfg_d      = wb_dat_i[7];
    end

    // Outputs are registered on entry to each bus state
    if ((state_q == IDLE) && (state_d == POLL)) begin
      cyc_d = 1'b1;
      stb_d = 1'b1;
      we_d  = 1'b0;
      adr_d = STATUS_ADR;
    end
    if ((state_q == DECIDE) && (state_d == TX_WR)) begin
      cyc_d = 1'b1;
      stb_d = 1'b1;
      we_d  = 1'b1;
      adr_d = BASE_ADR;
      dat_d = fifo_mem[rd_ptr_q];
    end
    if ((state_q == DECIDE) && (state_d == RX_RD)) begin
      cyc_d = 1'b1;
      stb_d = 1'b1;
      we_d  = 1'b0;
      adr_d = BASE_ADR;
    end

    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      prefer_rx_d = 1'b1;
    end
    count_d = count_q + CW'(push_c) - CW'(pop_c);

`ifdef USB_SERIAL_PUMP_RX_EN
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if ((state_q == RX_RD) && ack_c) begin
      rx_valid_d  = 1'b1;
      rx_data_d   = wb_dat_i;
      prefer_rx_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 8'h00;
      dat_q       <= 8'h00;
      to_cnt_q    <= '0;
      bus_error_q <= 1'b0;
      rx_avail_q  <= 1'b0;
      tx_space_q  <= 1'b0;
      cfg_q       <= 1'b0;
      prefer_rx_q <= 1'b0;
`ifdef USB_SERIAL_PUMP_RX_EN
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      to_cnt_q    <= to_cnt_d;
      bus_error_q <= bus_error_d;
      rx_avail_q  <= rx_avail_d;
      tx_space_q  <= tx_space_d;
      cfg_q       <= cfg_d;
      prefer_rx_q <= prefer_rx_d;
`ifdef USB_SERIAL_PUMP_RX_EN
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
`endif
    end
  end

  assign tx_level       = count_q;
  assign usb_configured = cfg_q;
  assign bus_error      = bus_error_q;
  assign wb_cyc_o       = cyc_q;
  assign wb_stb_o       = stb_q;
  assign wb_we_o        = we_q;
  assign wb_adr_o       = adr_q;
  assign wb_dat_o       = dat_q;

endmodule

// File: tb/tb_usb_serial_pump.sv
// Bench for usb_serial_pump: behavioural Wishbone slave logs every acked transfer;
// pushed TX bytes go to a scoreboard queue that is matched against logged writes.
`timescale 1ns/1ps
module tb_usb_serial_pump;

  localparam int unsigned TX_DEPTH = 8;
  localparam int unsigned LW       = $clog2(TX_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [LW-1:0] tx_level;
  logic          usb_configured;
  logic          bus_error;
  logic [7:0]    wb_adr_o;
  logic [7:0]    wb_dat_o;
  logic [7:0]    wb_dat_i = 8'h00;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic          wb_ack_i = 1'b0;

  always #5 clk = ~clk;

  usb_serial_pump #(.TX_DEPTH(TX_DEPTH), .BASE_ADR(8'h20), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .usb_configured(usb_configured), .bus_error(bus_error),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i)
  );

  typedef struct {
    logic [7:0] adr;
    logic       we;
    logic [7:0] dat;
  } txn_t;

  txn_t       log_q[$];
  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         max_level = 0;
  logic [7:0] status_byte = 8'h00;
  logic [7:0] rx_byte = 8'h00;
  bit         ack_rd_en = 1'b1;
  bit         ack_wr_en = 1'b1;

  // Slave: one-cycle ack, logs each acknowledged transfer
  always @(posedge clk) begin
    #1;
    if (wb_cyc_o && wb_stb_o && !wb_ack_i && (wb_we_o ? ack_wr_en : ack_rd_en)) begin
      wb_dat_i = (wb_adr_o == 8'h21) ? status_byte : rx_byte;
      wb_ack_i = 1'b1;
      log_q.push_back('{adr: wb_adr_o, we: wb_we_o, dat: (wb_we_o ? wb_dat_o : wb_dat_i)});
    end else begin
      wb_ack_i = 1'b0;
    end
  end

  // Offers a byte and leaves tx_valid high; returns once it has been accepted
  task automatic push_byte(input logic [7:0] b, input bit track);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 400) begin
      if (int'(tx_level) > max_level) max_level = int'(tx_level);
      @(negedge clk);
      n++;
    end
    if (int'(tx_level) > max_level) max_level = int'(tx_level);
    if (!tx_ready) begin
      checks++;
      errors++;
      $display("FAIL push_wait: tx_ready stayed 0 for byte %h, want 1", b);
    end else begin
      if (track) exp_q.push_back(b);
      @(negedge clk);
    end
  endtask

  task automatic drain_writes(input int max_cycles);
    txn_t t;
    logic [7:0] want;
    bit prev_poll = 1'b0;
    int n = 0;
    int extra = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      if (log_q.size() != 0) begin
        t = log_q.pop_front();
        if (t.we) begin
          want = exp_q.pop_front();
          checks++;
          if (t.adr !== 8'h20 || t.dat !== want || !prev_poll) begin
            errors++;
            $display("FAIL tx_write: adr=%h dat=%h polled=%0d, want adr=20 dat=%h polled=1",
                     t.adr, t.dat, prev_poll, want);
          end
          prev_poll = 1'b0;
        end else begin
          checks++;
          if (t.adr !== 8'h21) begin
            errors++;
            $display("FAIL poll_adr: read adr=%h, want 21", t.adr);
          end
          prev_poll = (t.adr == 8'h21);
        end
      end else begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL tx_drain_timeout: %0d bytes never written, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (12) @(negedge clk);
    while (log_q.size() != 0) begin
      t = log_q.pop_front();
      if (t.we) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL tx_extra_writes: %0d unexpected writes, want 0", extra);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL reset_tx_ready: got %b, want 0", tx_ready);
    end
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000 || wb_adr_o !== 8'h00 || wb_dat_o !== 8'h00) begin
      errors++; $display("FAIL reset_wb: cyc/stb/we=%b%b%b adr=%h dat=%h, want 000 00 00",
                         wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o);
    end
    checks++;
    if (tx_level !== LW'(0)) begin
      errors++; $display("FAIL reset_level: got %0d, want 0", tx_level);
    end
    checks++;
    if ({bus_error, usb_configured, rx_valid} !== 3'b000 || rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_status: err/cfg/rxv=%b%b%b rx_data=%h, want 000 00",
                         bus_error, usb_configured, rx_valid, rx_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_tx_ready: got %b, want 1", tx_ready);
    end
  endtask

  task automatic test_tx_basic();
    status_byte = 8'h82;
    repeat (4) @(negedge clk);
    log_q.delete();
    @(negedge clk);
    push_byte(8'h41, 1'b1);
    push_byte(8'h42, 1'b1);
    push_byte(8'h43, 1'b1);
    tx_valid = 1'b0;
    drain_writes(300);
    checks++;
    if (tx_level !== LW'(0) || usb_configured !== 1'b1) begin
      errors++; $display("FAIL tx_basic_end: level=%0d cfg=%b, want 0 1", tx_level, usb_configured);
    end
  endtask

  task automatic test_fifo_full();
    int bad = 0;
    int polls = 0;
    txn_t t;
    status_byte = 8'h00;
    repeat (12) @(negedge clk);
    log_q.delete();
    for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i), 1'b0);
    tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_level !== LW'(8) || tx_ready !== 1'b0) begin
      errors++; $display("FAIL fifo_full: level=%0d ready=%b, want 8 0", tx_level, tx_ready);
    end
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_level !== LW'(8)) begin
      errors++; $display("FAIL ninth_push: level=%0d, want 8", tx_level);
    end
    repeat (20) @(negedge clk);
    while (log_q.size() != 0) begin
      t = log_q.pop_front();
      if (t.we || t.adr !== 8'h21) bad++;
      else polls++;
    end
    checks++;
    if (bad != 0 || polls == 0) begin
      errors++; $display("FAIL full_only_polls: other=%0d polls=%0d, want 0 and >0", bad, polls);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int high = 0;
    int err_during = 0;
    while (wb_stb_o && n < 20) begin @(negedge clk); n++; end
    ack_rd_en = 1'b0;
    ack_wr_en = 1'b0;
    n = 0;
    while (!wb_stb_o && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!wb_stb_o) begin
      errors++; $display("FAIL timeout_start: stb=%b, want 1", wb_stb_o);
    end
    while (wb_stb_o && high < 20) begin
      if (bus_error) err_during++;
      high++;
      @(negedge clk);
    end
    checks++;
    if (high != 4 || err_during != 0) begin
      errors++; $display("FAIL timeout_len: stb cycles=%0d early_err=%0d, want 4 0", high, err_during);
    end
    checks++;
    if (bus_error !== 1'b1 || wb_cyc_o !== 1'b0) begin
      errors++; $display("FAIL bus_error_pulse: err=%b cyc=%b, want 1 0", bus_error, wb_cyc_o);
    end
    @(negedge clk);
    checks++;
    if (bus_error !== 1'b0) begin
      errors++; $display("FAIL bus_error_width: err=%b, want 0", bus_error);
    end
    checks++;
    if (tx_level !== LW'(8)) begin
      errors++; $display("FAIL timeout_fifo: level=%0d, want 8", tx_level);
    end
    n = 0;
    while (!(wb_stb_o && wb_adr_o == 8'h21) && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (!(wb_stb_o && wb_adr_o == 8'h21)) begin
      errors++; $display("FAIL poll_resume: stb=%b adr=%h, want 1 21", wb_stb_o, wb_adr_o);
    end
    ack_rd_en = 1'b1;
    ack_wr_en = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    ack_wr_en   = 1'b0;
    status_byte = 8'h82;
    while (!(wb_stb_o && wb_we_o) && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (!(wb_stb_o && wb_we_o)) begin
      errors++; $display("FAIL mid_write_start: stb=%b we=%b, want 1 1", wb_stb_o, wb_we_o);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || tx_level !== LW'(0) || bus_error !== 1'b0) begin
      errors++; $display("FAIL reset_abort: cyc=%b stb=%b level=%0d err=%b, want 0 0 0 0",
                         wb_cyc_o, wb_stb_o, tx_level, bus_error);
    end
    rst = 1'b0;
    ack_wr_en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_error !== 1'b0) begin
      errors++; $display("FAIL reset_no_error: err=%b, want 0", bus_error);
    end
    log_q.delete();
  endtask

  task automatic test_back_to_back();
    status_byte = 8'h82;
    max_level   = 0;
    repeat (4) @(negedge clk);
    log_q.delete();
    @(negedge clk);
    for (int i = 0; i < 12; i++) push_byte(8'h10 + 8'(i), 1'b1);
    tx_valid = 1'b0;
    checks++;
    if (max_level != int'(TX_DEPTH)) begin
      errors++; $display("FAIL b2b_fill: peak level=%0d, want %0d", max_level, TX_DEPTH);
    end
    drain_writes(600);
    checks++;
    if (tx_level !== LW'(0) || tx_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_end: level=%0d ready=%b, want 0 1", tx_level, tx_ready);
    end
  endtask

`ifdef USB_SERIAL_PUMP_RX_EN
  task automatic test_rx_round_robin();
    txn_t t;
    txn_t got[$];
    int n = 0;
    status_byte = 8'h00;
    rx_byte     = 8'h99;
    rx_ready    = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_byte(8'h55, 1'b0);
    tx_valid = 1'b0;
    status_byte = 8'h83;
    while (got.size() < 2 && n < 100) begin
      if (log_q.size() != 0) begin
        t = log_q.pop_front();
        if (t.we || t.adr != 8'h21) got.push_back(t);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (got.size() < 1 || !(got[0].we === 1'b1 && got[0].adr === 8'h20 && got[0].dat === 8'h55)) begin
      errors++; $display("FAIL rr_first_tx: %0d transfers seen, want write 20=55 first", got.size());
    end
    checks++;
    if (got.size() < 2 || !(got[1].we === 1'b0 && got[1].adr === 8'h20 && got[1].dat === 8'h99)) begin
      errors++; $display("FAIL rr_second_rx: %0d transfers seen, want read 20=99 second", got.size());
    end
    status_byte = 8'h00;
    repeat (6) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h99) begin
      errors++; $display("FAIL rx_hold: valid=%b data=%h, want 1 99", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h99) begin
      errors++; $display("FAIL rx_consume: valid=%b data=%h, want 0 99", rx_valid, rx_data);
    end
    log_q.delete();
  endtask
`else
  task automatic test_no_rx();
    int bad_valid = 0;
    int rd20 = 0;
    int polls = 0;
    txn_t t;
    status_byte = 8'h81;
    rx_byte     = 8'h99;
    log_q.delete();
    for (int i = 0; i < 60; i++) begin
      rx_ready = (i % 3 == 0);
      @(negedge clk);
      if (rx_valid !== 1'b0 || rx_data !== 8'h00) bad_valid++;
    end
    rx_ready = 1'b0;
    while (log_q.size() != 0) begin
      t = log_q.pop_front();
      if (t.adr == 8'h20) rd20++;
      else if (!t.we && t.adr == 8'h21) polls++;
    end
    checks++;
    if (bad_valid != 0) begin
      errors++; $display("FAIL no_rx_valid: %0d cycles with rx output active, want 0", bad_valid);
    end
    checks++;
    if (rd20 != 0 || polls == 0) begin
      errors++; $display("FAIL no_rx_reads: data-reg accesses=%0d polls=%0d, want 0 and >0", rd20, polls);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tx_basic();
    test_fifo_full();
    test_timeout();
    test_reset_mid_write();
    test_back_to_back();
`ifdef USB_SERIAL_PUMP_RX_EN
    test_rx_round_robin();
`else
    test_no_rx();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
